alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit integer ALU for the single-cycle MIPS datapath.
- Supports AND, OR, ADD, A AND NOT B, A OR NOT B, SUB, SLT, and a masked 16-bit pattern-match search.
- Produces a result, a zero flag and a signed-overflow flag.
- Outputs are registered: one clock, synchronous active-low reset, 1-cycle latency.

Parameters:
- N, 32, data width. Only N=32 is supported for the pattern op; the other ops are width-generic.

Ports:
- clk    in   1  clock; all state updates on the rising edge.
- rst_n  in   1  reset, synchronous, active-low.
- A      in   N  operand A.
- B      in   N  operand B. For the pattern op, B[31:16] is the don't-care mask and B[15:0] is the pattern.
- F      in   3  operation select.
- Y      out  N  result, registered.
- zero   out  1  registered; 1 when the registered Y is all zeros.
- OF     out  1  registered; signed overflow for ADD/SUB.

Behaviour:
- Reset: while rst_n=0 at a rising edge, Y<=0, zero<=1, OF<=0. Reset has priority over any operation in flight.
- Latency: A/B/F sampled at edge k; Y/zero/OF valid after edge k. No handshake; a new op is accepted every cycle.
- F encoding:
  - 000: Y=A&B
  - 001: Y=A|B
  - 010: Y=A+B
  - 011: PATTERN
  - 100: Y=A&~B
  - 101: Y=A|~B
  - 110: Y=A-B, computed as A+~B+1
  - 111: SLT
- ADD/SUB: results wrap modulo 2^N, carry-out discarded.
- ADD overflow: OF=1 when A and B have the same sign and Y's sign differs.
- SUB overflow: OF=1 when A and B signs differ and Y's sign differs from A.
- All other ops: OF=0.
- SLT: Y=1 if A<B as signed two's complement, else 0. Overflow-corrected, i.e. less = sign(A-B) XOR overflow(A-B). OF=0.
- zero: zero=(Y==0) for every op, including PATTERN.
- PATTERN:
  - Windows: 17 windows W_i=A[i+15:i], i=0..16.
  - Match condition: W_i matches when ((W_i XNOR B[15:0]) | B[31:16]) is all ones. A mask bit of 1 means that bit is ignored.
  - Y[15+i]=match_i for i=0..16, i.e. a bitmap in Y[31:15].
  - Y[14:5]=0.
  - Y[4:0]=popcount of the bitmap, range 0..17.
  - B all-ones mask: every window matches, so Y=FFFF8011.
  - OF=0.
- No X-propagation guards are required. Undefined F cannot occur, since all 8 codes are defined.

Decomposition:
- Package alu_pkg holds:
  - an enum alu_op_e with codes AND=3'b000, OR=3'b001, ADD=3'b010, PAT=3'b011, ANDN=3'b100, ORN=3'b101, SUB=3'b110, SLT=3'b111;
  - localparams PAT_W=16, PAT_WIN=17, CNT_W=5.
- Sub-module alu_pattern_match: combinational, taking A and B and producing the 32-bit pattern result (window compare plus popcount).
- The top-level module alu holds the adder/subtractor, the logic ops, the output mux and the output registers.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with arbitrary A/B/F -> Y=00000000, zero=1, OF=0. Then release with A=000000FF, B=00000001, F=010 -> after 1 edge Y=00000100, zero=0.
- ADD/SUB overflow:
  - ADD 7FFFFFFF+00000001 -> Y=80000000, OF=1.
  - ADD 7FFFFFFF+80000000 -> Y=FFFFFFFF, OF=0.
  - SUB 7FFFFFFF-80000000 -> Y=FFFFFFFF, OF=1.
  - SUB 00000001-00000001 -> Y=0, zero=1.
- SLT:
  - A=FFFFFFFF, B=0 -> Y=1, zero=0.
  - A=0000007F, B=FFFFFFFA -> Y=0, zero=1.
  - A=FFFFFFF9, B=FFFFFFFA -> Y=1.
- Logic ops:
  - F=100, A=FFFFFFFF, B=1 -> FFFFFFFE.
  - F=101, A=0, B=0 -> FFFFFFFF.
  - F=001, A=12345678, B=87654321 -> 97755779.
- Pattern:
  - A=FFF7FFFF, B=0040FFFF -> Y=10078005.
  - A=22221222, B=0F002222 -> Y=80080002.
  - A=55555555, B=AAAAFFFF -> Y=AAAA8009.
  - A=0A55AA55, B=F0F00A05 -> Y=850A8006.
- Back-to-back: change F/A/B every cycle across all 8 ops -> each result appears exactly 1 cycle later, with no bubbles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and pattern-search geometry for the MIPS ALU.
package alu_pkg;

   typedef enum logic [2:0] {
      AND  = 3'b000,
      OR   = 3'b001,
      ADD  = 3'b010,
      PAT  = 3'b011,
      ANDN = 3'b100,
      ORN  = 3'b101,
      SUB  = 3'b110,
      SLT  = 3'b111
   } alu_op_e;

   localparam int PAT_W   = 16;
   localparam int PAT_WIN = 17;
   localparam int CNT_W   = 5;

endpackage

// File: rtl/alu_pattern_match.sv
// Masked 16-bit pattern search over the 17 windows of a 32-bit word.
// Output layout: match bitmap in [31:15], zeros in [14:5], popcount in [4:0].
module alu_pattern_match
   import alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic [PAT_W-1:0] win;
   logic             match;
   logic [CNT_W-1:0] cnt;

   always_comb begin
      y     = '0;
      cnt   = '0;
      win   = '0;
      match = 1'b0;
      for (int i = 0; i < PAT_WIN; i++) begin
         win   = a[i +: PAT_W];
         // A mask bit of 1 forces that bit position to count as equal.
         match = &((win ~^ b[PAT_W-1:0]) | b[31:PAT_W]);
         y[PAT_W-1+i] = match;
         cnt   = cnt + CNT_W'(match);
      end
      y[CNT_W-1:0] = cnt;
   end

endmodule

// File: rtl/alu.sv
// Single-cycle MIPS datapath ALU with registered result, zero and signed-overflow flags.
module alu
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [2:0]   F,
   output logic [N-1:0] Y,
   output logic         zero,
   output logic         OF
);

   alu_op_e              op_p0;
   logic                 sub_p0;
   logic        [N-1:0]  b_eff_p0;
   logic signed [N-1:0]  sum_p0;
   logic                 ovf_p0;
   logic        [N-1:0]  pat_p0;
   logic        [N-1:0]  y_p0;
   logic                 of_p0;

   assign op_p0    = alu_op_e'(F);
   assign sub_p0   = (op_p0 == SUB) || (op_p0 == SLT);
   assign b_eff_p0 = sub_p0 ? ~B : B;
   assign sum_p0   = $signed(A + b_eff_p0 + N'(sub_p0));
   // Same-sign operands into the adder with a differing result sign covers both ADD and SUB.
   assign ovf_p0   = (A[N-1] == b_eff_p0[N-1]) && (sum_p0[N-1] != A[N-1]);

   generate
      if (N == 32) begin : g_pat
         alu_pattern_match u_pat (
            .a (A),
            .b (B),
            .y (pat_p0)
         );
      end else begin : g_no_pat
         assign pat_p0 = '0;
      end
   endgenerate

   always_comb begin
      y_p0  = '0;
      of_p0 = 1'b0;
      unique case (op_p0)
         AND:  y_p0 = A & B;
         OR:   y_p0 = A | B;
         ADD:  begin y_p0 = sum_p0; of_p0 = ovf_p0; end
         PAT:  y_p0 = pat_p0;
         ANDN: y_p0 = A & ~B;
         ORN:  y_p0 = A | ~B;
         SUB:  begin y_p0 = sum_p0; of_p0 = ovf_p0; end
         SLT:  y_p0 = N'(sum_p0[N-1] ^ ovf_p0);
         default: y_p0 = '0;
      endcase
   end

   // ---- stage p0 -> registered outputs ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Y    <= '0;
         zero <= 1'b1;
         OF   <= 1'b0;
      end else begin
         Y    <= y_p0;
         zero <= (y_p0 == '0);
         OF   <= of_p0;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Randomized and directed bench for alu against a plain-arithmetic reference model.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  F;
   logic [31:0] Y;
   logic        zero;
   logic        OF;

   int n_vec;
   int n_cmp;
   int n_err;

   alu #(.N(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .F     (F),
      .Y     (Y),
      .zero  (zero),
      .OF    (OF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
      end
   endtask

   // Reference: result and overflow from the arithmetic definitions, not from adder bits.
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f);
      logic [31:0] y;
      logic        of;
      longint      s;
      int          cnt;
      logic [15:0] w;
      logic [15:0] care;
      y  = '0;
      of = 1'b0;
      s  = 0;
      case (f)
         3'd0: y = a & b;
         3'd1: y = a | b;
         3'd2: begin
            y = a + b;
            s = longint'($signed(a)) + longint'($signed(b));
            of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd3: begin
            cnt  = 0;
            care = ~b[31:16];
            for (int i = 0; i <= 16; i++) begin
               w = 16'(a >> i);
               if ((w & care) == (b[15:0] & care)) begin
                  y[15+i] = 1'b1;
                  cnt++;
               end
            end
            y[4:0] = 5'(cnt);
         end
         3'd4: y = a & ~b;
         3'd5: y = a | ~b;
         3'd6: begin
            y = a - b;
            s = longint'($signed(a)) - longint'($signed(b));
            of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         default: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
      return {of, y};
   endfunction

   // Apply one op for a single cycle and check the registered outputs one edge later.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
      logic [32:0] m;
      A = a;
      B = b;
      F = f;
      m = model(a, b, f);
      n_vec++;
      @(posedge clk);
      #1;
      check("Y",    Y,           m[31:0]);
      check("zero", 32'(zero),   32'(m[31:0] == 32'd0));
      check("OF",   32'(OF),     32'(m[32]));
   endtask

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
   } vec_t;

   vec_t dir[$];

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  rf;
      n_vec = 0;
      n_cmp = 0;
      n_err = 0;

      // Reset held for two edges with arbitrary inputs.
      rst_n = 1'b0;
      A = $urandom;
      B = $urandom;
      F = 3'($urandom);
      @(posedge clk);
      A = $urandom;
      F = 3'd2;
      @(posedge clk);
      #1;
      check("rst_Y",    Y,         32'h0);
      check("rst_zero", 32'(zero), 32'd1);
      check("rst_OF",   32'(OF),   32'd0);

      rst_n = 1'b1;
      do_op(32'h000000FF, 32'h00000001, 3'b010);
      check("rel_Y", Y, 32'h00000100);

      dir.push_back('{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000});
      dir.push_back('{3'b010, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF});
      dir.push_back('{3'b110, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF});
      dir.push_back('{3'b110, 32'h00000001, 32'h00000001, 32'h00000000});
      dir.push_back('{3'b111, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
      dir.push_back('{3'b111, 32'h0000007F, 32'hFFFFFFFA, 32'h00000000});
      dir.push_back('{3'b111, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'h00000001});
      dir.push_back('{3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000});
      dir.push_back('{3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001});
      dir.push_back('{3'b100, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE});
      dir.push_back('{3'b101, 32'h00000000, 32'h00000000, 32'hFFFFFFFF});
      dir.push_back('{3'b001, 32'h12345678, 32'h87654321, 32'h97755779});
      dir.push_back('{3'b011, 32'hFFF7FFFF, 32'h0040FFFF, 32'h10078005});
      dir.push_back('{3'b011, 32'h22221222, 32'h0F002222, 32'h80080002});
      dir.push_back('{3'b011, 32'h55555555, 32'hAAAAFFFF, 32'hAAAA8009});
      dir.push_back('{3'b011, 32'h0A55AA55, 32'hF0F00A05, 32'h850A8006});
      dir.push_back('{3'b011, 32'h12345678, 32'hFFFF0000, 32'hFFFF8011});

      foreach (dir[i]) begin
         do_op(dir[i].a, dir[i].b, dir[i].f);
         check($sformatf("dir%0d", i), Y, dir[i].y);
      end

      // Back-to-back random ops, one per cycle, cycling through every opcode.
      for (int k = 0; k < 400; k++) begin
         ra = $urandom;
         rb = $urandom;
         rf = 3'(k % 8);
         if ((k / 8) % 2 == 1) rf = 3'($urandom);
         if (rf == 3'd3) begin
            rb[31:16] = 16'($urandom) | 16'($urandom) | 16'($urandom);
            if ($urandom_range(0, 1) == 1) rb[15:0] = 16'(ra >> $urandom_range(0, 16));
         end
         if ($urandom_range(0, 7) == 0) rb = ra;
         if ($urandom_range(0, 7) == 0) ra = {1'b0, 31'($urandom)} | 32'h40000000;
         do_op(ra, rb, rf);
      end

      // Reset asserted mid-stream overrides the op presented that cycle.
      rst_n = 1'b0;
      A = 32'h7FFFFFFF;
      B = 32'h00000001;
      F = 3'b010;
      @(posedge clk);
      #1;
      check("mid_rst_Y",    Y,         32'h0);
      check("mid_rst_zero", 32'(zero), 32'd1);
      check("mid_rst_OF",   32'(OF),   32'd0);
      rst_n = 1'b1;
      do_op(32'h7FFFFFFF, 32'h00000001, 3'b010);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
